ff_ovrflw_mon: RTL and testbench

- Write-clock-domain monitor for FIFO overflow flags from the FIFO flag generator.
- Per interface: counts dropped-write cycles, holds sticky status bits, raises a maskable interrupt.
- Exposes everything through a simple local-bus register interface.
- Drives the per-interface clear_flags pulse back into the flag generator, whose clear_clk is tied to wr_clk.

---
 rtl/ff_ovrflw_mon.sv | 119 +++++++++++
 tb/tb_ff_ovrflw_mon.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/ff_ovrflw_mon.sv
// FIFO overflow monitor in the wr_clk domain: per-interface saturating drop counters,
// sticky status, maskable level interrupt and local-bus registers. Optional capture
// timestamps are enabled by defining FF_OVRFLW_MON_TSTAMP_EN.
module ff_ovrflw_mon #(
  parameter int NUM_INTFS = 4,
  parameter int CNTR_W    = 16,
  parameter int LB_ADDR_W = 8
) (
  input  logic                 wr_clk,
  input  logic                 wr_clk_rst_n,
  input  logic [NUM_INTFS-1:0] ff_ovrflw,
  input  logic                 lb_wr_en,
  input  logic                 lb_rd_en,
  input  logic [LB_ADDR_W-1:0] lb_addr,
  input  logic [31:0]          lb_wr_data,
  output logic                 lb_rd_valid,
  output logic [31:0]          lb_rd_data,
  output logic [NUM_INTFS-1:0] clear_flags,
  output logic                 ovrflw_irq
);

  localparam logic [LB_ADDR_W-1:0] ADDR_STATUS = LB_ADDR_W'(8'h00);
  localparam logic [LB_ADDR_W-1:0] ADDR_MASK   = LB_ADDR_W'(8'h01);
  localparam logic [LB_ADDR_W-1:0] ADDR_CTRL   = LB_ADDR_W'(8'h02);
  localparam logic [CNTR_W-1:0]    CNT_MAX     = '1;

  logic [CNTR_W-1:0]    r_cnt [NUM_INTFS];
  logic [NUM_INTFS-1:0] r_sticky;
  logic [NUM_INTFS-1:0] r_mask;
  logic [NUM_INTFS-1:0] r_clear_flags;
  logic                 r_rd_valid;
  logic [31:0]          r_rd_data;
  logic                 r_irq;

  logic [NUM_INTFS-1:0] w_w1c;
  logic [NUM_INTFS-1:0] w_clr;
  logic                 w_wr_mask;
  logic [31:0]          w_rd_mux;
  logic                 w_unused;

  assign w_w1c     = (lb_wr_en && lb_addr == ADDR_STATUS) ? lb_wr_data[NUM_INTFS-1:0] : '0;
  assign w_clr     = (lb_wr_en && lb_addr == ADDR_CTRL)   ? lb_wr_data[NUM_INTFS-1:0] : '0;
  assign w_wr_mask = lb_wr_en && lb_addr == ADDR_MASK;
  assign w_unused  = ^lb_wr_data;

`ifdef FF_OVRFLW_MON_TSTAMP_EN
  logic [31:0] r_ts_cnt;
  logic [31:0] r_ts [NUM_INTFS];

  // Capture only on the 0->1 sticky edge; a same-cycle CTRL clear suppresses it.
  always_ff @(posedge wr_clk or negedge wr_clk_rst_n) begin
    if (!wr_clk_rst_n) begin
      r_ts_cnt <= '0;
      for (int i = 0; i < NUM_INTFS; i++) r_ts[i] <= '0;
    end else begin
      r_ts_cnt <= r_ts_cnt + 32'd1;
      for (int i = 0; i < NUM_INTFS; i++) begin
        if (w_clr[i])
          r_ts[i] <= '0;
        else if (ff_ovrflw[i] && !r_sticky[i])
          r_ts[i] <= r_ts_cnt;
      end
    end
  end
`endif

  // Clear beats overflow; overflow beats write-1-to-clear.
  always_ff @(posedge wr_clk or negedge wr_clk_rst_n) begin
    if (!wr_clk_rst_n) begin
      for (int i = 0; i < NUM_INTFS; i++) r_cnt[i] <= '0;
      r_sticky      <= '0;
      r_mask        <= '0;
      r_clear_flags <= '0;
      r_irq         <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_INTFS; i++) begin
        if (w_clr[i])
          r_cnt[i] <= '0;
        else if (ff_ovrflw[i] && r_cnt[i] != CNT_MAX)
          r_cnt[i] <= r_cnt[i] + CNTR_W'(1);
      end
      r_sticky      <= ((r_sticky & ~w_w1c) | ff_ovrflw) & ~w_clr;
      r_clear_flags <= w_clr;
      r_irq         <= |(r_sticky & r_mask);
      if (w_wr_mask) r_mask <= lb_wr_data[NUM_INTFS-1:0];
    end
  end

  always_comb begin
    w_rd_mux = '0;
    if (lb_addr == ADDR_STATUS) w_rd_mux = 32'(r_sticky);
    if (lb_addr == ADDR_MASK)   w_rd_mux = 32'(r_mask);
    for (int i = 0; i < NUM_INTFS; i++) begin
      if (lb_addr == LB_ADDR_W'(16 + i)) w_rd_mux = 32'(r_cnt[i]);
`ifdef FF_OVRFLW_MON_TSTAMP_EN
      if (lb_addr == LB_ADDR_W'(32 + i)) w_rd_mux = r_ts[i];
`endif
    end
  end

  // Read handshake: lb_rd_en is a one-cycle request with no backpressure; exactly one
  // cycle later lb_rd_valid is high for one cycle with data sampled before any
  // same-cycle write. lb_rd_data is zero whenever lb_rd_valid is low.
  always_ff @(posedge wr_clk or negedge wr_clk_rst_n) begin
    if (!wr_clk_rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= lb_rd_en;
      r_rd_data  <= lb_rd_en ? w_rd_mux : 32'd0;
    end
  end

  assign lb_rd_valid = r_rd_valid;
  assign lb_rd_data  = r_rd_data;
  assign clear_flags = r_clear_flags;
  assign ovrflw_irq  = r_irq;

endmodule

// File: tb/tb_ff_ovrflw_mon.sv
// Directed plus randomized bench for ff_ovrflw_mon against an array-based register model;
// a second instance with CNTR_W=4 shares all inputs to exercise counter saturation.
module tb_ff_ovrflw_mon;

  logic        wr_clk = 1'b0;
  logic        wr_clk_rst_n = 1'b0;
  logic [3:0]  ff_ovrflw = '0;
  logic        lb_wr_en = 1'b0;
  logic        lb_rd_en = 1'b0;
  logic [7:0]  lb_addr = '0;
  logic [31:0] lb_wr_data = '0;
  logic        lb_rd_valid, s_rd_valid;
  logic [31:0] lb_rd_data, s_rd_data;
  logic [3:0]  clear_flags, s_clear_flags;
  logic        ovrflw_irq, s_irq;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned tb_cyc = 0;

  int unsigned m_cnt [4];
  int unsigned m_cnt_sat [4];
  logic [3:0]  m_sticky;
  logic [3:0]  m_mask;
  logic [31:0] m_ts [4];

  always #5 wr_clk = ~wr_clk;

  // Cycles since reset release; equals the DUT timestamp value during each cycle.
  always @(posedge wr_clk or negedge wr_clk_rst_n) begin
    if (!wr_clk_rst_n) tb_cyc = 0;
    else tb_cyc = tb_cyc + 1;
  end

  ff_ovrflw_mon #(.NUM_INTFS(4), .CNTR_W(16), .LB_ADDR_W(8)) u_dut (
    .wr_clk(wr_clk), .wr_clk_rst_n(wr_clk_rst_n), .ff_ovrflw(ff_ovrflw),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_rd_valid(lb_rd_valid), .lb_rd_data(lb_rd_data),
    .clear_flags(clear_flags), .ovrflw_irq(ovrflw_irq)
  );

  ff_ovrflw_mon #(.NUM_INTFS(4), .CNTR_W(4), .LB_ADDR_W(8)) u_dut_sat (
    .wr_clk(wr_clk), .wr_clk_rst_n(wr_clk_rst_n), .ff_ovrflw(ff_ovrflw),
    .lb_wr_en(lb_wr_en), .lb_rd_en(lb_rd_en), .lb_addr(lb_addr), .lb_wr_data(lb_wr_data),
    .lb_rd_valid(s_rd_valid), .lb_rd_data(s_rd_data),
    .clear_flags(s_clear_flags), .ovrflw_irq(s_irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 0; m_cnt_sat[i] = 0; m_ts[i] = 0;
    end
    m_sticky = '0;
    m_mask   = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] addr, input bit sat);
    if (addr == 8'h00) return {28'd0, m_sticky};
    if (addr == 8'h01) return {28'd0, m_mask};
    if (addr >= 8'h10 && addr <= 8'h13) return sat ? m_cnt_sat[addr - 8'h10] : m_cnt[addr - 8'h10];
`ifdef FF_OVRFLW_MON_TSTAMP_EN
    if (addr >= 8'h20 && addr <= 8'h23) return m_ts[addr - 8'h20];
`endif
    return 32'd0;
  endfunction

  // One clock: apply inputs, predict from the model, advance the model, check at negedge.
  task automatic step(input logic [3:0] ovf, input logic wr, input logic rd,
                      input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd, exp_rd_sat;
    logic [3:0]  exp_clr, w1c;
    logic        exp_irq;
    ff_ovrflw = ovf; lb_wr_en = wr; lb_rd_en = rd; lb_addr = addr; lb_wr_data = wdata;
    exp_rd     = rd ? model_read(addr, 1'b0) : 32'd0;
    exp_rd_sat = rd ? model_read(addr, 1'b1) : 32'd0;
    exp_irq    = |(m_sticky & m_mask);
    exp_clr    = (wr && addr == 8'h02) ? wdata[3:0] : 4'd0;
    w1c        = (wr && addr == 8'h00) ? wdata[3:0] : 4'd0;
    for (int i = 0; i < 4; i++) begin
      if (exp_clr[i]) begin
        m_cnt[i] = 0; m_cnt_sat[i] = 0; m_sticky[i] = 1'b0; m_ts[i] = 0;
      end else if (ovf[i]) begin
        if (!m_sticky[i]) m_ts[i] = tb_cyc;
        if (m_cnt[i] < 65535) m_cnt[i]++;
        if (m_cnt_sat[i] < 15) m_cnt_sat[i]++;
        m_sticky[i] = 1'b1;
      end else if (w1c[i]) begin
        m_sticky[i] = 1'b0;
      end
    end
    if (wr && addr == 8'h01) m_mask = wdata[3:0];
    @(negedge wr_clk);
    check("rd_valid", {31'd0, lb_rd_valid}, {31'd0, rd});
    check("rd_data", lb_rd_data, exp_rd);
    check("rd_data_sat", s_rd_data, exp_rd_sat);
    check("clear_flags", {28'd0, clear_flags}, {28'd0, exp_clr});
    check("irq", {31'd0, ovrflw_irq}, {31'd0, exp_irq});
    check("irq_sat", {31'd0, s_irq}, {31'd0, exp_irq});
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(4'd0, 1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  task automatic rd(input logic [7:0] addr);
    step(4'd0, 1'b0, 1'b1, addr, 32'd0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    step(4'd0, 1'b1, 1'b0, addr, data);
  endtask

  task automatic do_reset();
    wr_clk_rst_n = 1'b0;
    ff_ovrflw = '0; lb_wr_en = 1'b0; lb_rd_en = 1'b0; lb_addr = '0; lb_wr_data = '0;
    model_reset();
    repeat (2) @(negedge wr_clk);
    check("rst_rd_valid", {31'd0, lb_rd_valid}, 32'd0);
    check("rst_rd_data", lb_rd_data, 32'd0);
    check("rst_clear_flags", {28'd0, clear_flags}, 32'd0);
    check("rst_irq", {31'd0, ovrflw_irq}, 32'd0);
    wr_clk_rst_n = 1'b1;
  endtask

  logic [7:0] addr_tbl [12] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13,
                                8'h20, 8'h21, 8'h22, 8'h23, 8'h7f};

  initial begin
    do_reset();

    // Reset values and read latency.
    rd(8'h00); rd(8'h01); rd(8'h10); idle(1);

    // Overflow on interface 1 with its interrupt enabled.
    wr(8'h01, 32'h2);
    for (int k = 0; k < 5; k++) step(4'b0010, 1'b0, 1'b0, 8'h00, 32'd0);
    idle(2);
    rd(8'h11); rd(8'h00); rd(8'h10);

    // Long overflow on interface 0 saturates the 4-bit instance.
    for (int k = 0; k < 20; k++) step(4'b0001, 1'b0, 1'b0, 8'h00, 32'd0);
    rd(8'h10);

    // W1C collides with overflow (set wins), then plain W1C drops irq.
    wr(8'h01, 32'h3);
    step(4'b0001, 1'b1, 1'b0, 8'h00, 32'h1);
    rd(8'h00);
    wr(8'h00, 32'h3);
    idle(2);
    rd(8'h00);

    // CTRL clear coincident with an interface-0 overflow, plus interface 2 state.
    step(4'b0100, 1'b0, 1'b0, 8'h00, 32'd0);
    step(4'b0001, 1'b1, 1'b0, 8'h02, 32'h5);
    idle(2);
    rd(8'h10); rd(8'h12); rd(8'h02); rd(8'h7f);

    // Back-to-back CTRL writes, then read and write the mask together.
    wr(8'h02, 32'h1); wr(8'h02, 32'h2); wr(8'h02, 32'h8); idle(1);
    step(4'd0, 1'b1, 1'b1, 8'h01, 32'h4);
    rd(8'h01);

    // Timestamp on interface 3: first capture sticks, second does not recapture.
    wr(8'h02, 32'h8); idle(2);
    step(4'b1000, 1'b0, 1'b0, 8'h00, 32'd0);
    idle(99);
    step(4'b1000, 1'b0, 1'b0, 8'h00, 32'd0);
    rd(8'h23); rd(8'h20);

    // Reset during a pending read produces no valid.
    @(negedge wr_clk);
    lb_rd_en = 1'b1; lb_addr = 8'h11;
    #2 wr_clk_rst_n = 1'b0;
    @(negedge wr_clk);
    check("abort_rd_valid", {31'd0, lb_rd_valid}, 32'd0);
    do_reset();
    rd(8'h11);

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      logic [3:0] ovf;
      ovf = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      step(ovf, ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           addr_tbl[$urandom_range(0, 11)], $urandom);
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
